iq_pack_buffer: RTL and testbench
=================================

# iq_pack_buffer

Downstream stage of the distorter MAC engine: joins the engine's real (`c_o`) and imaginary (`d_o`) 16-bit output streams into one packed 32-bit IQ word stream. Words are buffered in a small FIFO that absorbs streamer back-pressure. Output samples are counted against a programmed frame length, and a one-cycle `done` pulse is raised for the control FSM. Sits between the engine outputs and the HWPE output streamer.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: buffer depth in words; power of two, ≥2.
- `CNT_LEN`, 1024: maximum frame length; the counter is `$clog2(CNT_LEN)+1` bits wide.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `re_i`  hwpe_stream sink  16  real sample, driven by the engine's `c_o`.
- `im_i`  hwpe_stream sink  16  imaginary sample, driven by the engine's `d_o`.
- `iq_o`  hwpe_stream source  32  packed word `{im[15:0], re[15:0]}`; `strb` is all ones.
- `ctrl_i`  in  `ctrl_iq_t`  fields: `clear`, `enable`, `len` (counter width).
- `flags_o`  out  `flags_iq_t`  fields: `cnt`, `level` (`$clog2(FIFO_DEPTH)+1` bits), `empty`, `full`, `done`.

## Operation
- Join:
  - `re_i.ready = im_i.ready = enable & ~full & re_i.valid & im_i.valid`.
  - A push occurs only when both sides handshake in the same cycle, so the two lanes never slip apart.
  - If only one input is valid, neither input is accepted.
- Pack:
  - `re` goes to bits [15:0] and `im` to bits [31:16`].
  - No arithmetic is applied; input `strb` is ignored.
- FIFO:
  - Circular buffer with a write pointer, a read pointer, and a `level` counter.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `full = (level == FIFO_DEPTH)`; `empty = (level == 0)`.
  - Push and pop in the same cycle leave `level` unchanged.
  - No push is accepted while `full`, even if a pop happens that cycle: `full` is registered and input ready does not depend on output ready.
  - There is no empty-bypass path.
- Output:
  - `iq_o.valid = enable & ~empty`.
  - `iq_o.data` is the word at the read pointer.
  - Once valid, data is held stable until `iq_o.ready`.
- Frame counter:
  - `cnt` increments on each `iq_o` handshake.
  - If `len != 0` and the handshake occurs with `cnt == len-1`, `cnt` is set to 0 and `done` is asserted for exactly the next cycle.
  - If `len == 0`, the frame is unbounded: `done` never asserts and `cnt` wraps at its width.
- `enable` low:
  - All readies and `iq_o.valid` are 0.
  - FIFO contents, pointers and counter are held.
- `clear` (synchronous) and `rst_i`:
  - Empty the FIFO (pointers and `level` to 0); set `cnt` to 0 and `done` to 0.
  - Memory contents are not cleared.
  - `rst_i` has priority over `clear`, and `clear` has priority over `enable`.
  - A clear issued mid-frame discards buffered words; no `done` is produced for the aborted frame.

## Timing
- Reset values:
  - `iq_o.valid=0`, `re_i.ready=0`, `im_i.ready=0`.
  - `flags_o`: `cnt=0`, `level=0`, `empty=1`, `full=0`, `done=0`.
- Latency: an input handshake in cycle N gives `iq_o.valid` in cycle N+1 (FIFO previously empty).
- Throughput: one word per cycle sustained while the sink holds `ready` high.
- Back-pressure: with the sink stalled, `FIFO_DEPTH` words are accepted, then input readies drop the cycle `full` rises.
- `done` is registered; `flags_o.cnt` reflects the post-increment value one cycle after the handshake.
- Readies depend combinationally only on `valid`s, `enable` and registered `full`. No valid depends on any ready.

## Structure
- `iq_package`:
  - `IQ_CNT_LEN` constant.
  - `ctrl_iq_t` and `flags_iq_t` typedefs.
  - `IQ_WORD_W = 32` constant.
- Sub-module `iq_fifo`:
  - Parameterised circular buffer: push/pop, level, full/empty, sync clear.
  - The top level holds the join logic, packing, output gating and frame counter.

## Test plan
- Reset, then `enable=1`, `len=4`; drive pairs (re,im) = (0x0001,0x8000) … (0x0004,0x8003) with sink always ready.
  - Outputs are 0x80000001 … 0x80030004, one per cycle, each appearing 1 cycle after its input.
  - `done` pulses once, the cycle after the 4th handshake; `cnt` returns to 0.
- Hold `re_i.valid=1` with `im_i.valid=0` for 5 cycles, then assert `im_i.valid`.
  - Both readies stay 0 for the 5 cycles.
  - Exactly one word is pushed, on the first cycle both are valid.
- `FIFO_DEPTH=4`, sink `ready=0`, stream 6 pairs.
  - 4 words accepted; `full=1`, `level=4`; input readies 0.
  - Release the sink: 6 words drain in order, with no loss and no duplication.
- `len=3`, stream 2 words, assert `clear` for 1 cycle, then stream 3 words.
  - After the clear: `level=0`, `cnt=0`, no `done`.
  - The single `done` pulse follows the 3rd word after the clear.
- `len=0`, stream `2^(cnt width)+2` words.
  - `done` never asserts; `cnt` wraps to 0 and then reads 2.
- Toggle `enable` low for 3 cycles mid-stream with 2 words buffered.
  - `iq_o.valid` and the readies drop to 0 for those cycles.
  - Buffered words are emitted intact after re-enable.

Source files
------------

// File: rtl/iq_pack_buffer_pkg.sv
// Shared types and constants for the IQ pack buffer: control/flag bundles and
// the widths of the real/imaginary samples and the packed output word.
package iq_package;

    localparam int unsigned IQ_CNT_LEN    = 1024;
    localparam int unsigned IQ_CNT_W      = $clog2(IQ_CNT_LEN) + 1;
    localparam int unsigned IQ_FIFO_DEPTH = 4;
    localparam int unsigned IQ_LEVEL_W    = $clog2(IQ_FIFO_DEPTH) + 1;
    localparam int unsigned IQ_SAMPLE_W   = 16;
    localparam int unsigned IQ_WORD_W     = 32;

    typedef struct packed {
        logic                clear;
        logic                enable;
        logic [IQ_CNT_W-1:0] len;
    } ctrl_iq_t;

    typedef struct packed {
        logic [IQ_CNT_W-1:0]   cnt;
        logic [IQ_LEVEL_W-1:0] level;
        logic                  empty;
        logic                  full;
        logic                  done;
    } flags_iq_t;

endpackage

// File: rtl/iq_pack_buffer_fifo.sv
// Circular word buffer with write/read pointers and an occupancy counter.
// Memory contents survive reset and clear; only the bookkeeping is zeroed.
module iq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [AW:0]   LEVEL_ONE  = 1;
    localparam logic [AW:0]   LEVEL_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LEVEL_FULL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/iq_pack_buffer.sv
// Joins the real and imaginary sample streams into packed {im, re} words,
// buffers them, and counts delivered words against a programmed frame length.
module iq_pack_buffer
    import iq_package::*;
#(
    parameter int unsigned FIFO_DEPTH = IQ_FIFO_DEPTH,
    parameter int unsigned CNT_LEN    = IQ_CNT_LEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     re_valid_i,
    input  logic [IQ_SAMPLE_W-1:0]   re_data_i,
    input  logic [IQ_SAMPLE_W/8-1:0] re_strb_i,
    output logic                     re_ready_o,
    input  logic                     im_valid_i,
    input  logic [IQ_SAMPLE_W-1:0]   im_data_i,
    input  logic [IQ_SAMPLE_W/8-1:0] im_strb_i,
    output logic                     im_ready_o,
    output logic                     iq_valid_o,
    output logic [IQ_WORD_W-1:0]     iq_data_o,
    output logic [IQ_WORD_W/8-1:0]   iq_strb_o,
    input  logic                     iq_ready_i,
    input  ctrl_iq_t                 ctrl_i,
    output flags_iq_t                flags_o
);

    localparam int unsigned CNT_W   = $clog2(CNT_LEN) + 1;
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // valid/ready: a transfer happens on a rising edge where both are high.
    // A source never waits for ready before raising valid and keeps its data
    // stable while valid is high and ready is low.
    logic                 join_ready;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LEVEL_W-1:0]   fifo_level;
    logic [IQ_WORD_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]     cnt_q;
    logic                 done_q;
    logic                 frame_end;
    logic                 unused_strb;

    // Both lanes are taken together or not at all, so re/im never slip apart.
    assign join_ready = ctrl_i.enable & ~fifo_full & re_valid_i & im_valid_i;
    assign re_ready_o = join_ready;
    assign im_ready_o = join_ready;

    assign iq_valid_o = ctrl_i.enable & ~fifo_empty;
    assign iq_data_o  = fifo_rdata;
    assign iq_strb_o  = '1;
    assign pop        = iq_valid_o & iq_ready_i;

    assign unused_strb = ^{re_strb_i, im_strb_i};

    iq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IQ_WORD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (ctrl_i.clear),
        .push_i  (join_ready),
        .wdata_i ({im_data_i, re_data_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // A zero length means an unbounded frame: the counter just wraps.
    assign frame_end = (ctrl_i.len != '0) && (cnt_q == ctrl_i.len - CNT_ONE);

    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                if (frame_end) begin
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign flags_o = '{cnt:   cnt_q,
                       level: fifo_level,
                       empty: fifo_empty,
                       full:  fifo_full,
                       done:  done_q};

endmodule

// File: tb/tb_iq_pack_buffer.sv
// Bench for iq_pack_buffer: directed scenarios plus randomized streams, all
// checked every cycle against a queue-based model of the buffer and frame count.
module tb_iq_pack_buffer;
    import iq_package::*;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = IQ_CNT_W;
    localparam int CNT_MOD = 1 << CNT_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re_valid = 1'b0, im_valid = 1'b0, iq_ready = 1'b0;
    logic [15:0] re_data = '0, im_data = '0;
    logic [1:0]  re_strb = '0, im_strb = '0;
    logic        re_ready, im_ready, iq_valid;
    logic [31:0] iq_data;
    logic [3:0]  iq_strb;
    ctrl_iq_t    ctrl = '0;
    flags_iq_t   flags;

    logic [31:0] exp_q[$];
    int unsigned m_cnt = 0;
    bit          m_done = 1'b0;
    int          n_checks = 0, n_errors = 0;
    int          n_done_obs = 0, n_pushed = 0, n_popped = 0;

    always #5 clk = ~clk;

    iq_pack_buffer #(.FIFO_DEPTH(DEPTH), .CNT_LEN(IQ_CNT_LEN)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .re_valid_i (re_valid),
        .re_data_i  (re_data),
        .re_strb_i  (re_strb),
        .re_ready_o (re_ready),
        .im_valid_i (im_valid),
        .im_data_i  (im_data),
        .im_strb_i  (im_strb),
        .im_ready_o (im_ready),
        .iq_valid_o (iq_valid),
        .iq_data_o  (iq_data),
        .iq_strb_o  (iq_strb),
        .iq_ready_i (iq_ready),
        .ctrl_i     (ctrl),
        .flags_o    (flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered just after a rising edge; drives inputs, checks outputs against
    // the model, advances the model, and returns just after the next edge.
    task automatic cycle(input bit rv, input bit iv, input logic [15:0] rd,
                         input logic [15:0] id, input bit rdy, output bit acc);
        bit ex_full, ex_in, ex_out, nd;
        re_valid = rv; im_valid = iv; re_data = rd; im_data = id; iq_ready = rdy;
        re_strb = 2'($urandom()); im_strb = 2'($urandom());
        #2;
        ex_full = (exp_q.size() == DEPTH);
        ex_in   = ctrl.enable && !ex_full && rv && iv;
        ex_out  = ctrl.enable && (exp_q.size() != 0);
        check("re_ready", 32'(re_ready), 32'(ex_in));
        check("im_ready", 32'(im_ready), 32'(ex_in));
        check("iq_valid", 32'(iq_valid), 32'(ex_out));
        if (ex_out) check("iq_data", iq_data, exp_q[0]);
        check("iq_strb", 32'(iq_strb), 32'hF);
        check("level", 32'(flags.level), 32'(exp_q.size()));
        check("empty", 32'(flags.empty), 32'(exp_q.size() == 0));
        check("full", 32'(flags.full), 32'(ex_full));
        check("cnt", 32'(flags.cnt), m_cnt);
        check("done", 32'(flags.done), 32'(m_done));
        if (flags.done) n_done_obs++;
        acc = ex_in;
        if (ctrl.clear) begin
            exp_q.delete();
            m_cnt  = 0;
            m_done = 1'b0;
        end else begin
            nd = 1'b0;
            if (ex_out && rdy) begin
                void'(exp_q.pop_front());
                n_popped++;
                if (ctrl.len != 0 && m_cnt == 32'(ctrl.len) - 1) begin
                    m_cnt = 0;
                    nd    = 1'b1;
                end else begin
                    m_cnt = (m_cnt + 1) % CNT_MOD;
                end
            end
            if (ex_in) begin
                exp_q.push_back({id, rd});
                n_pushed++;
            end
            m_done = nd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; re_valid = 1'b0; im_valid = 1'b0; iq_ready = 1'b0; ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
    endtask

    task automatic clear_pulse();
        bit acc;
        ctrl.clear = 1'b1;
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
        ctrl.clear = 1'b0;
    endtask

    // Each lane raises valid independently and holds it until the joint transfer.
    task automatic stream(input int n_words, input int src_pct, input int sink_pct,
                          input int en_pct, input int budget);
        int          sent = 0, cyc = 0;
        bit          rp = 1'b0, ip = 1'b0, acc;
        logic [15:0] wr = 16'($urandom()), wi = 16'($urandom());
        while ((sent < n_words || exp_q.size() != 0) && cyc < budget) begin
            if (sent < n_words) begin
                if (!rp && $urandom_range(99) < src_pct) rp = 1'b1;
                if (!ip && $urandom_range(99) < src_pct) ip = 1'b1;
            end
            ctrl.enable = ($urandom_range(99) < en_pct);
            cycle(rp, ip, wr, wi, ($urandom_range(99) < sink_pct), acc);
            if (acc) begin
                sent++;
                rp = 1'b0; ip = 1'b0;
                wr = 16'($urandom()); wi = 16'($urandom());
            end
            cyc++;
        end
        check("stream_budget", 32'(cyc < budget), 32'd1);
        ctrl.enable = 1'b1;
        idle(2);
    endtask

    initial begin
        bit acc;
        int base_done, base_pop, base_push, got_acc;

        do_reset();
        idle(1);

        // Basic packing, one word per cycle, done after the 4th transfer.
        ctrl.enable = 1'b1; ctrl.len = 4;
        base_done = n_done_obs; base_pop = n_popped;
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b1, 16'(i), 16'(16'h8000 + i - 1), 1'b1, acc);
            check("s1_accept", 32'(acc), 32'd1);
        end
        idle(2);
        check("s1_done_pulses", 32'(n_done_obs - base_done), 32'd1);
        check("s1_words_out", 32'(n_popped - base_pop), 32'd4);
        check("s1_cnt_end", 32'(flags.cnt), 32'd0);

        // One lane valid alone is never accepted.
        base_push = n_pushed;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 16'h1234, 16'h5678, 1'b1, acc);
            check("s2_lone_valid", 32'(acc), 32'd0);
        end
        cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1, acc);
        check("s2_join", 32'(acc), 32'd1);
        idle(2);
        check("s2_pushed", 32'(n_pushed - base_push), 32'd1);

        // Back-pressure: sink stalled, six pairs offered.
        base_pop = n_popped; got_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 16'(16'h1000 + got_acc), 16'(16'h2000 + got_acc), 1'b0, acc);
            if (acc) got_acc++;
        end
        check("s3_accepted", 32'(got_acc), 32'd4);
        check("s3_level", 32'(flags.level), 32'd4);
        check("s3_full", 32'(flags.full), 32'd1);
        check("s3_in_ready", 32'(re_ready), 32'd0);
        stream(6 - got_acc, 100, 100, 100, 50);
        check("s3_drained", 32'(n_popped - base_pop), 32'd6);

        // Clear mid-frame discards buffered words and restarts the frame.
        clear_pulse();
        ctrl.len = 3;
        base_done = n_done_obs;
        stream(2, 100, 100, 100, 50);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 16'(i), 16'(i), 1'b0, acc);
        check("s4_buffered", 32'(flags.level), 32'd2);
        clear_pulse();
        check("s4_clr_level", 32'(flags.level), 32'd0);
        check("s4_clr_cnt", 32'(flags.cnt), 32'd0);
        check("s4_clr_done", 32'(flags.done), 32'd0);
        check("s4_no_done", 32'(n_done_obs - base_done), 32'd0);
        stream(3, 100, 100, 100, 50);
        check("s4_done_once", 32'(n_done_obs - base_done), 32'd1);

        // Unbounded frame: counter wraps, never done.
        clear_pulse();
        ctrl.len = 0;
        base_done = n_done_obs;
        stream(CNT_MOD + 2, 100, 100, 100, CNT_MOD + 100);
        check("s5_cnt_wrap", 32'(flags.cnt), 32'd2);
        check("s5_no_done", 32'(n_done_obs - base_done), 32'd0);

        // Enable low for three cycles with two words buffered.
        clear_pulse();
        ctrl.len = 5;
        base_pop = n_popped;
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 16'(16'hA0 + i), 16'(16'hB0 + i), 1'b0, acc);
        ctrl.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 16'h00C0, 16'h00D0, 1'b1, acc);
            check("s6_gated", 32'(acc), 32'd0);
        end
        ctrl.enable = 1'b1;
        cycle(1'b1, 1'b1, 16'h00C0, 16'h00D0, 1'b1, acc);
        check("s6_resume", 32'(acc), 32'd1);
        stream(0, 100, 100, 100, 20);
        check("s6_drained", 32'(n_popped - base_pop), 32'd3);

        // Randomized traffic with random frame lengths and enable gaps.
        for (int r = 0; r < 6; r++) begin
            ctrl.len = CNT_W'($urandom_range(0, 6));
            clear_pulse();
            stream(60, 70, 60, 85, 1500);
        end

        // Reset with words in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'(i), 16'(i), 1'b0, acc);
        do_reset();
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
